countdown_timer: RTL and testbench

//  Loadable down-counter/timer; complement of the free-running up-counter.

---
 rtl/countdown_timer_pkg.sv | 13 +
 rtl/countdown_timer.sv | 101 ++++++++++
 tb/tb_countdown_timer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared constants and state encoding for the loadable countdown timer.
package countdown_timer_pkg;

   localparam int CDT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOADED = 2'd1,
      RUN    = 2'd2,
      PAUSED = 2'd3
   } state_t;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with valid/ready load, pause/stop and one-cycle done.
// Define CDT_AUTO_RELOAD_EN for periodic reload at terminal count.
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int WIDTH = CDT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] load_val,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic             start,
   input  logic             pause,
   input  logic             stop,
   output logic [WIDTH-1:0] cnt,
   output logic             busy,
   output logic             done
);

   state_t           state;
   state_t           nxt_state;
   logic [WIDTH-1:0] nxt_cnt;
   logic             nxt_done;
   logic             hs;
   logic             last;

   assign hs   = load_valid && load_ready;
   // a zero load counts as already terminal, so cnt never wraps
   assign last = (cnt <= WIDTH'(1));

`ifdef CDT_AUTO_RELOAD_EN
   logic [WIDTH-1:0] reload;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         reload <= '0;
      else if (hs)
         reload <= load_val;
   end
`endif

   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt;
      nxt_done  = 1'b0;
      unique case (state)
         IDLE: begin
            if (hs) begin
               nxt_cnt   = load_val;
               nxt_state = LOADED;
            end
         end
         LOADED: begin
            if (hs)
               nxt_cnt = load_val;
            if (start)
               nxt_state = pause ? PAUSED : RUN;
         end
         RUN: begin
            if (stop)
               nxt_state = IDLE;
            else if (pause)
               nxt_state = PAUSED;
            else if (last) begin
               nxt_done = 1'b1;
`ifdef CDT_AUTO_RELOAD_EN
               nxt_cnt  = reload;
`else
               nxt_cnt   = '0;
               nxt_state = IDLE;
`endif
            end else
               nxt_cnt = cnt - WIDTH'(1);
         end
         PAUSED: begin
            if (stop)
               nxt_state = IDLE;
            else if (!pause)
               nxt_state = RUN;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         done       <= 1'b0;
         busy       <= 1'b0;
         load_ready <= 1'b1;
      end else begin
         state      <= nxt_state;
         cnt        <= nxt_cnt;
         done       <= nxt_done;
         busy       <= (nxt_state == RUN) || (nxt_state == PAUSED);
         load_ready <= (nxt_state == IDLE) || (nxt_state == LOADED);
      end
   end

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized self-checking bench for countdown_timer against a cycle model.
// Covers the CDT_AUTO_RELOAD_EN variant when that macro is defined.
module tb_countdown_timer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] load_val;
   logic         load_valid;
   logic         load_ready;
   logic         start;
   logic         pause;
   logic         stop;
   logic [W-1:0] cnt;
   logic         busy;
   logic         done;

   int n_tests = 0;
   int n_fail  = 0;

   // model: mode 0 waiting empty, 1 armed, 2 counting, 3 frozen
   int m_mode;
   int m_cnt;
   int m_reload;
   bit m_done;

   always #5 clk = ~clk;

   countdown_timer #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_val   (load_val),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .start      (start),
      .pause      (pause),
      .stop       (stop),
      .cnt        (cnt),
      .busy       (busy),
      .done       (done)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".cnt"}, int'(cnt), m_cnt);
      chk({tag, ".done"}, int'(done), int'(m_done));
      chk({tag, ".busy"}, int'(busy), int'(m_mode >= 2));
      chk({tag, ".rdy"}, int'(load_ready), int'(m_mode < 2));
   endtask

   task automatic model_reset();
      m_mode   = 0;
      m_cnt    = 0;
      m_reload = 0;
      m_done   = 1'b0;
   endtask

   task automatic model_step();
      m_done = 1'b0;
      if (m_mode >= 2) begin
         if (stop)
            m_mode = 0;
         else if (m_mode == 3) begin
            if (!pause) m_mode = 2;
         end else if (pause)
            m_mode = 3;
         else if (m_cnt <= 1) begin
            m_done = 1'b1;
`ifdef CDT_AUTO_RELOAD_EN
            m_cnt = m_reload;
`else
            m_cnt  = 0;
            m_mode = 0;
`endif
         end else
            m_cnt = m_cnt - 1;
      end else begin
         if (load_valid) begin
            m_cnt    = int'(load_val);
            m_reload = int'(load_val);
         end
         if (m_mode == 1 && start)
            m_mode = pause ? 3 : 2;
         else if (load_valid)
            m_mode = 1;
      end
   endtask

   task automatic drv(input bit lv, input int v, input bit s,
                      input bit p, input bit sp);
      load_valid = lv;
      load_val   = W'(v);
      start      = s;
      pause      = p;
      stop       = sp;
   endtask

   task automatic cycle(input string tag);
      model_step();
      @(posedge clk);
      #1;
      check_all(tag);
      @(negedge clk);
   endtask

   task automatic idle_cycles(input string tag, input int n);
      drv(0, 0, 0, 0, 0);
      for (int i = 0; i < n; i++) cycle(tag);
   endtask

   task automatic async_reset(input string tag);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all(tag);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      drv(0, 0, 0, 0, 0);
      model_reset();
      repeat (2) @(negedge clk);
      check_all("rst");
      rst = 1'b0;

      // reset in the middle of a run
      drv(1, 5, 0, 0, 0); cycle("t1ld");
      drv(0, 0, 1, 0, 0); cycle("t1st");
      chk("t1_cnt5", int'(cnt), 5);
      @(posedge clk);
      async_reset("t1rst");

      // load 3 and count down
      drv(1, 3, 1, 0, 0); cycle("t2ld");
      drv(0, 0, 1, 0, 0); cycle("t2st");
      idle_cycles("t2run", 2);
      chk("t2_nodone", int'(done), 0);
      cycle("t2end");
      chk("t2_done", int'(done), 1);
      idle_cycles("t2post", 2);

      // zero load must not wrap
      drv(1, 0, 0, 0, 0); cycle("t3ld");
      drv(0, 0, 1, 0, 0); cycle("t3st");
      idle_cycles("t3run", 3);

      // pause at 7 for four cycles
      drv(1, 10, 0, 0, 0); cycle("t4ld");
      drv(0, 0, 1, 0, 0); cycle("t4st");
      idle_cycles("t4run", 3);
      chk("t4_cnt7", int'(cnt), 7);
      drv(0, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) cycle("t4pz");
      idle_cycles("t4res", 12);

      // stop at 4, load attempt while running is refused
      drv(1, 6, 0, 0, 0); cycle("t5ld");
      drv(0, 0, 1, 0, 0); cycle("t5st");
      drv(1, 9, 0, 0, 0); cycle("t5busyld");
      idle_cycles("t5run", 1);
      chk("t5_cnt4", int'(cnt), 4);
      drv(0, 0, 0, 0, 1); cycle("t5stop");
      idle_cycles("t5post", 3);

      // same-cycle load+start from armed state restarts with new value
      drv(1, 2, 0, 0, 0); cycle("t6ld");
      drv(1, 4, 1, 0, 0); cycle("t6ldst");
      idle_cycles("t6run", 6);

`ifdef CDT_AUTO_RELOAD_EN
      drv(1, 2, 0, 0, 0); cycle("t7ld");
      drv(0, 0, 1, 0, 0); cycle("t7st");
      idle_cycles("t7run", 8);
      drv(0, 0, 0, 0, 1); cycle("t7stop");
      idle_cycles("t7post", 2);
`endif

      for (int i = 0; i < 3000; i++) begin
         drv(($urandom_range(0, 99) < 30),
             ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                         : int'($urandom_range(0, 12)),
             ($urandom_range(0, 99) < 25),
             ($urandom_range(0, 99) < 15),
             ($urandom_range(0, 99) < 4));
         cycle("rnd");
         if ($urandom_range(0, 299) == 0) begin
            @(posedge clk);
            async_reset("rndrst");
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
